// File: rtl/serial_greater_equal_pkg.sv
// Shared serial-ALU definitions: FSM state encoding and result-word bit positions.
package serial_greater_equal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned RESULT_FLAG_BIT = 0;
  localparam int unsigned RESULT_EQ_BIT   = 1;

endpackage

// File: rtl/serial_sub_bit.sv
// One-bit full subtractor cell (a - b - borrow) for bit-serial ALU operations.
module serial_sub_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a_i ^ b_i ^ borrow_in;
  assign borrow_out = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_in);

endmodule

// File: rtl/serial_greater_equal.sv
// Bit-serial a >= b comparator (LSB first, one borrow flop), signed/unsigned per transaction.
// Optional equality flag in out[1] when SERIAL_GE_EQ_FLAG_EN is defined.
module serial_greater_equal #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out
);

  import serial_greater_equal_pkg::*;

  if (N < 2) begin : g_bad_width
    $error("serial_greater_equal: N must be >= 2");
  end

  localparam int unsigned CNT_W = (N < 2) ? 1 : $clog2(N);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             is_signed_q, is_signed_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_q, out_d;

  logic diff;
  logic borrow_out;
  logic lt_u;
  logic lt_s;
  logic lt;

  serial_sub_bit u_sub_bit (
    .a_i        (a_q[0]),
    .b_i        (b_q[0]),
    .borrow_in  (borrow_q),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

`ifdef SERIAL_GE_EQ_FLAG_EN
  logic any_diff_q, any_diff_d;
`else
  logic unused_diff;
  assign unused_diff = diff;
`endif

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    is_signed_d = is_signed_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    lt_u        = borrow_out;
    lt_s        = (a_msb_q ^ b_msb_q) ? a_msb_q : borrow_out;
    lt          = is_signed_q ? lt_s : lt_u;
`ifdef SERIAL_GE_EQ_FLAG_EN
    any_diff_d  = any_diff_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d         = a;
          b_d         = b;
          is_signed_d = is_signed;
          a_msb_d     = a[N-1];
          b_msb_d     = b[N-1];
          borrow_d    = 1'b0;
          cnt_d       = '0;
          in_ready_d  = 1'b0;
          state_d     = BUSY;
`ifdef SERIAL_GE_EQ_FLAG_EN
          any_diff_d  = 1'b0;
`endif
        end
      end

      BUSY: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = borrow_out;
`ifdef SERIAL_GE_EQ_FLAG_EN
        any_diff_d = any_diff_q | diff;
`endif
        if (cnt_q == LAST_BIT) begin
          // Counter holds at N-1; the result word is formed from the final borrow
          out_d                  = '0;
          out_d[RESULT_FLAG_BIT] = ~lt;
`ifdef SERIAL_GE_EQ_FLAG_EN
          out_d[RESULT_EQ_BIT]   = ~(any_diff_q | diff);
`endif
          out_valid_d            = 1'b1;
          state_d                = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      is_signed_q <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      is_signed_q <= is_signed_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

`ifdef SERIAL_GE_EQ_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_diff_q <= 1'b0;
    end else begin
      any_diff_q <= any_diff_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_serial_greater_equal.sv
// Self-checking bench for serial_greater_equal (N = 8): directed vectors plus random operands.
module tb_serial_greater_equal;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] dut_out;

  int n_checks;
  int n_pass;

  serial_greater_equal #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dut_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic ms);
    logic [N-1:0] r;
    r = '0;
    if (ms) r[0] = ($signed(ma) >= $signed(mb));
    else    r[0] = (ma >= mb);
`ifdef SERIAL_GE_EQ_FLAG_EN
    r[1] = (ma == mb);
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction; stall = cycles out_ready is held low after out_valid,
  // early = out_ready raised from the accept cycle, poke = stray in_valid during the stall.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic ts,
                        input int stall, input bit early, input bit poke, input string tag);
    logic [N-1:0] exp;
    int lat;
    int w;
    exp = model(ta, tb_v, ts);
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    a         = ta;
    b         = tb_v;
    is_signed = ts;
    in_valid  = 1'b1;
    out_ready = early;
    tick();
    in_valid  = 1'b0;
    a         = N'($urandom);
    b         = N'($urandom);
    is_signed = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(N + 1));
    check({tag, " result"}, 32'(dut_out), 32'(exp));
    if (!early) begin
      for (int i = 0; i < stall; i++) begin
        if (poke && i == 5) begin
          a = 8'h00; b = 8'hFF; is_signed = 1'b0; in_valid = 1'b1;
        end
        tick();
        in_valid = 1'b0;
        check({tag, " stall out"}, 32'(dut_out), 32'(exp));
        check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    check({tag, " post out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " post out hold"}, 32'(dut_out), 32'(exp));
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rs;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out", 32'(dut_out), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(8'h05, 8'h03, 1'b0, 0, 1'b0, 1'b0, "u 5>=3");
    check("u 5>=3 value", 32'(dut_out), 32'h01);
    run_op(8'h03, 8'h05, 1'b0, 0, 1'b0, 1'b0, "u 3>=5");
    check("u 3>=5 value", 32'(dut_out), 32'h00);
    run_op(8'h80, 8'h7F, 1'b1, 0, 1'b0, 1'b0, "s min>=max");
    check("s min>=max value", 32'(dut_out), 32'h00);
    run_op(8'h80, 8'h7F, 1'b0, 0, 1'b0, 1'b0, "u 80>=7f");
    check("u 80>=7f value", 32'(dut_out), 32'h01);
    run_op(8'hA5, 8'hA5, 1'b1, 0, 1'b0, 1'b0, "s eq");
`ifdef SERIAL_GE_EQ_FLAG_EN
    check("s eq value", 32'(dut_out), 32'h03);
`else
    check("s eq value", 32'(dut_out), 32'h01);
`endif
    run_op(8'h05, 8'h03, 1'b0, 20, 1'b0, 1'b1, "backpressure");
    run_op(8'h7F, 8'h80, 1'b1, 0, 1'b1, 1'b0, "early ready");
    check("early ready value", 32'(dut_out), 32'h01);

    // Abort mid-BUSY; previous result word is nonzero so the clear is observable
    run_op(8'h10, 8'h01, 1'b0, 0, 1'b0, 1'b0, "pre reset");
    a = 8'h01; b = 8'h02; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("busy in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out", 32'(dut_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(8'hFF, 8'h01, 1'b1, 0, 1'b0, 1'b0, "after reset");
    check("after reset value", 32'(dut_out), 32'h00);

    for (int k = 0; k < 1000; k++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (k % 16 == 0) rb = ra;
      rs = 1'($urandom);
      run_op(ra, rb, rs, int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_greater_equal.md
Name: serial_greater_equal

Overview:
- Bit-serial, multi-cycle comparator. Computes a >= b as the complement of the ALU less-than operation; signed or unsigned mode is selected per transaction.
- Processes one bit per clock, LSB first, using a single borrow flop. This makes it a low-area alternative to the parallel less-than path.
- Sits beside the ALU operation modules. Operands arrive on a valid/ready input channel; the result leaves on a valid/ready output channel in ALU result format.
- Result format: N-bit word, flag in bit 0, upper bits zero.

Parameters:
- N, 8, operand and result width; N >= 2 is required (elaboration error otherwise).

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset; synchronous deassertion is handled outside the block
- in_valid  input  1  operand transaction valid
- in_ready  output  1  block can accept operands
- a  input  N  operand A
- b  input  N  operand B
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned compare
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out  output  N  result word; bit 0 = (a >= b)

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - state = IDLE, in_ready = 1, out_valid = 0, out = 0.
  - Internal shift registers, borrow flop and bit counter = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b and is_signed; clear borrow and counter; go to BUSY.
  - Input values are ignored when in_valid = 0.
- BUSY:
  - in_ready = 0.
  - Each cycle, process bit i (i = counter) of the latched a - b:
    - diff = a_i ^ b_i ^ borrow
    - borrow_next = (~a_i & b_i) | (~(a_i ^ b_i) & borrow)
  - Shift the operand registers right by one and increment the counter.
  - After bit N-1 is processed (exactly N BUSY cycles), compute:
    - lt_u = final borrow
    - lt_s = (a_msb ^ b_msb) ? a_msb : lt_u
    - lt = is_signed ? lt_s : lt_u
    - out[0] = ~lt, out[N-1:1] = 0
  - Then go to DONE with out_valid = 1.
- DONE:
  - out_valid = 1 and out is held stable until out_valid & out_ready.
  - On that handshake: clear out_valid and go to IDLE (in_ready = 1 on the next cycle). out holds its last value.
- Latency: accept edge to out_valid asserted = N+1 clock edges. Minimum throughput is one result per N+2 cycles.
- No back-to-back overlap: no new operand is accepted while BUSY or DONE, and in_ready is low in both states.
- out_ready held low in DONE: the block stalls indefinitely with no loss of the result.
- out_ready high before out_valid has no effect.
- MSB sign bits are captured at accept time and are not taken from the shifted registers.
- Counter width is $clog2(N); the last-bit compare is against N-1, so there is no wrap past N-1.
- Boundary results:
  - a == b → out[0] = 1.
  - Signed compare of min vs max (a = 0x80, b = 0x7F, N = 8) → out[0] = 0.
- rst_n asserted mid-BUSY or in DONE: the operation is aborted and all outputs return to reset values immediately. No partial result is ever presented.

Optional Feature:
- Macro: SERIAL_GE_EQ_FLAG_EN.
- Defined: an extra equality flop is cleared at accept and set on any diff = 1 bit during BUSY. out[1] = ~any_diff (1 when a == b). Remaining upper bits stay zero.
- Undefined: out[1] = 0, no equality flop is built, and behaviour is otherwise identical.

Decomposition:
- Shared ALU package holds:
  - the FSM state enum type (IDLE/BUSY/DONE)
  - localparams RESULT_FLAG_BIT = 0 and RESULT_EQ_BIT = 1
- One natural sub-module: serial_sub_bit. It is the combinational one-bit subtractor cell (inputs a_i, b_i, borrow_in; outputs diff, borrow_out), reusable by future serial ALU operations.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- Unsigned: a = 0x05, b = 0x03, is_signed = 0 → after 9 cycles out_valid = 1, out = 0x01. Repeat with a = 0x03, b = 0x05 → out = 0x00.
- Signed sign-mismatch: a = 0x80, b = 0x7F, is_signed = 1 → out = 0x00. Same operands with is_signed = 0 → out = 0x01.
- Equality: a = b = 0xA5, is_signed = 1 → out = 0x01, or out = 0x03 with SERIAL_GE_EQ_FLAG_EN defined.
- Backpressure: out_ready held low 20 cycles after out_valid → out stable, in_ready = 0 throughout. A new in_valid pulse during that time is ignored. Releasing out_ready → in_ready = 1 one cycle later.
- Reset mid-op: assert rst_n low at BUSY cycle 4 → out_valid = 0, in_ready = 1, out = 0 asynchronously. A following transaction (a = 0xFF, b = 0x01, is_signed = 1) → out = 0x00.
- Random: 1000 random a, b and is_signed values with random out_ready stalls → every out[0] matches the reference model ~(a < b), upper bits zero, latency exactly N+1.
